// File: rtl/tile_fb_double_buffer.sv
// Double-buffered tile framebuffer: the scan reads the front RAM while the writer fills the back RAM.
// Buffers swap at frame start on writer request; define TILE_FB_AUTO_SWAP_EN for free-running toggling.
module tile_fb_double_buffer #(
    parameter int DATA_W  = 8,
    parameter int TILE_PX = 20,
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24,
    parameter int H_W     = 10,
    parameter int V_W     = 10,
    localparam int ADDR_W = $clog2(GRID_W * GRID_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              front_sel,
    input  logic [H_W-1:0]    pix_h,
    input  logic [V_W-1:0]    pix_v,
    input  logic              pix_de,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int NUM_TILES_I = GRID_W * GRID_H;
    localparam logic [31:0] NUM_TILES = 32'(NUM_TILES_I);
    localparam logic [31:0] H_LIMIT   = 32'(GRID_W * TILE_PX);
    localparam logic [31:0] V_LIMIT   = 32'(GRID_H * TILE_PX);
    localparam logic [31:0] TILE_U    = 32'(TILE_PX);
    localparam logic [31:0] GRID_W_U  = 32'(GRID_W);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t            state_q, state_d;
    logic              front_sel_q, front_sel_d;
    logic              origin_q, origin_d;
    logic              wr_err_q, wr_err_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              in_grid_q, in_grid_d;
    logic              de_q, de_d;
    logic              in_grid2_q, in_grid2_d;
    logic              de2_q, de2_d;
    logic              sel2_q, sel2_d;

    logic [31:0]       col, row;
    logic              in_grid, origin, fs, wr_ok, swap_fire;

    logic [DATA_W-1:0] mem0 [0:NUM_TILES_I-1];
    logic [DATA_W-1:0] mem1 [0:NUM_TILES_I-1];
    logic [DATA_W-1:0] ram0_dout, ram1_dout;
    logic [ADDR_W-1:0] ram0_addr, ram1_addr;
    logic              ram0_we, ram1_we;

    always_comb begin
        col        = 32'(pix_h) / TILE_U;
        row        = 32'(pix_v) / TILE_U;
        in_grid    = (32'(pix_h) < H_LIMIT) && (32'(pix_v) < V_LIMIT);
        origin     = (pix_h == '0) && (pix_v == '0);
        fs         = origin && !origin_q;
        wr_ok      = wr_en && (32'(wr_addr) < NUM_TILES);

        origin_d   = origin;
        wr_err_d   = wr_en && !wr_ok;
        rd_addr_d  = in_grid ? ADDR_W'(row * GRID_W_U + col) : '0;
        in_grid_d  = in_grid;
        de_d       = pix_de;
        in_grid2_d = in_grid_q;
        de2_d      = de_q;
        sel2_d     = front_sel_q;
    end

    // Swap decision; a request arriving on the frame-start cycle is serviced immediately.
    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
`ifdef TILE_FB_AUTO_SWAP_EN
        state_d   = IDLE;
        swap_fire = fs;
`else
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    if (fs) swap_fire = 1'b1;
                    else    state_d   = PENDING;
                end
            end
            PENDING: begin
                if (fs) begin
                    swap_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`endif
        front_sel_d = front_sel_q ^ swap_fire;
    end

`ifdef TILE_FB_AUTO_SWAP_EN
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            origin_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_addr_q   <= '0;
            in_grid_q   <= 1'b0;
            de_q        <= 1'b0;
            in_grid2_q  <= 1'b0;
            de2_q       <= 1'b0;
            sel2_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            origin_q    <= origin_d;
            wr_err_q    <= wr_err_d;
            rd_addr_q   <= rd_addr_d;
            in_grid_q   <= in_grid_d;
            de_q        <= de_d;
            in_grid2_q  <= in_grid2_d;
            de2_q       <= de2_d;
            sel2_q      <= sel2_d;
        end
    end

    // Each RAM has one port: the back RAM sees the writer, the front RAM sees the scan.
    always_comb begin
        ram0_we   = wr_ok && !rst && front_sel_q;
        ram1_we   = wr_ok && !rst && !front_sel_q;
        ram0_addr = front_sel_q ? wr_addr : rd_addr_q;
        ram1_addr = front_sel_q ? rd_addr_q : wr_addr;
    end

    always_ff @(posedge clk) begin
        if (ram0_we) mem0[ram0_addr] <= wr_data;
        ram0_dout <= mem0[ram0_addr];
    end

    always_ff @(posedge clk) begin
        if (ram1_we) mem1[ram1_addr] <= wr_data;
        ram1_dout <= mem1[ram1_addr];
    end

    assign rd_data      = in_grid2_q ? (sel2_q ? ram1_dout : ram0_dout) : '0;
    assign rd_valid     = de2_q;
    assign wr_err       = wr_err_q;
    assign front_sel    = front_sel_q;
    assign swap_pending = (state_q == PENDING);
    assign swap_done    = swap_fire && !rst;

endmodule

// File: tb/tb_tile_fb_double_buffer.sv
// Directed bench for tile_fb_double_buffer: read-probe table plus hand sequences for swap corners.
// Define TILE_FB_AUTO_SWAP_EN on both files to exercise the free-running swap build.
module tb_tile_fb_double_buffer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int H_W    = 10;
    localparam int V_W    = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;
    logic              swap_req;
    logic              swap_pending;
    logic              swap_done;
    logic              front_sel;
    logic [H_W-1:0]    pix_h;
    logic [V_W-1:0]    pix_v;
    logic              pix_de;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string             name;
        int                h;
        int                v;
        logic              de;
        logic [DATA_W-1:0] exp_data;
        logic              exp_valid;
    } probe_t;

    probe_t tbl [6];

    tile_fb_double_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_err       (wr_err),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .front_sel    (front_sel),
        .pix_h        (pix_h),
        .pix_v        (pix_v),
        .pix_de       (pix_de),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        pix_h  = H_W'(700);
        pix_v  = V_W'(700);
        pix_de = 1'b0;
    endtask

    task automatic probe(input string name, input int h, input int v, input logic de,
                         input logic [DATA_W-1:0] ed, input logic ev);
        pix_h  = H_W'(h);
        pix_v  = V_W'(v);
        pix_de = de;
        tick();
        check({name, "_lat1_valid"}, 32'(rd_valid), 32'(0));
        set_idle();
        tick();
        check({name, "_data"}, 32'(rd_data), 32'(ed));
        check({name, "_valid"}, 32'(rd_valid), 32'(ev));
    endtask

    task automatic write_tile(input int a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        check("wr_err_inrange", 32'(wr_err), 32'(0));
    endtask

    // One frame start: origin for a single cycle, swap_done sampled mid-cycle, then two idle cycles.
    task automatic frame(output logic sd);
        pix_h = '0;
        pix_v = '0;
        #1 sd = swap_done;
        tick();
        set_idle();
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic sd;
        int   cnt;

        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        swap_req = 1'b0;
        set_idle();
        do_reset();

        check("rst_front_sel", 32'(front_sel), 32'(0));
        check("rst_swap_pending", 32'(swap_pending), 32'(0));
        check("rst_swap_done", 32'(swap_done), 32'(0));
        check("rst_wr_err", 32'(wr_err), 32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));

`ifdef TILE_FB_AUTO_SWAP_EN
        for (int i = 0; i < 4; i++) begin
            frame(sd);
            check($sformatf("auto_swap_done_%0d", i), 32'(sd), 32'(1));
            check($sformatf("auto_front_sel_%0d", i), 32'(front_sel), 32'((i % 2) == 0));
            check($sformatf("auto_pending_%0d", i), 32'(swap_pending), 32'(0));
        end
`else
        // Fill the back buffer (RAM1) and request a swap.
        write_tile(5, 8'hA5);
        write_tile(33, 8'h22);
        write_tile(767, 8'h77);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("req_pending", 32'(swap_pending), 32'(1));
        check("req_front_sel", 32'(front_sel), 32'(0));
        frame(sd);
        check("swap1_done", 32'(sd), 32'(1));
        check("swap1_front_sel", 32'(front_sel), 32'(1));
        check("swap1_pending", 32'(swap_pending), 32'(0));

        tbl[0] = '{"tile5",     100, 0,   1'b1, 8'hA5, 1'b1};
        tbl[1] = '{"tile33",    21,  21,  1'b1, 8'h22, 1'b1};
        tbl[2] = '{"tile767",   639, 479, 1'b1, 8'h77, 1'b1};
        tbl[3] = '{"oob_h",     640, 10,  1'b1, 8'h00, 1'b1};
        tbl[4] = '{"de_low",    100, 0,   1'b0, 8'hA5, 1'b0};
        tbl[5] = '{"oob_v",     5,   500, 1'b1, 8'h00, 1'b1};
        for (int i = 0; i < 6; i++)
            probe(tbl[i].name, tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].exp_data, tbl[i].exp_valid);

        // Back buffer is now RAM0; without a request the display must not change.
        write_tile(5, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            frame(sd);
            check($sformatf("noreq_done_%0d", i), 32'(sd), 32'(0));
            check($sformatf("noreq_front_%0d", i), 32'(front_sel), 32'(1));
        end
        probe("noreq_old_front", 100, 0, 1'b1, 8'hA5, 1'b1);

        // Request, write and frame start all on one cycle.
        pix_h    = '0;
        pix_v    = '0;
        swap_req = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = ADDR_W'(40);
        wr_data  = 8'h99;
        #1;
        check("same_cyc_done", 32'(swap_done), 32'(1));
        check("same_cyc_pending_pre", 32'(swap_pending), 32'(0));
        tick();
        swap_req = 1'b0;
        wr_en    = 1'b0;
        set_idle();
        check("same_cyc_front", 32'(front_sel), 32'(0));
        check("same_cyc_pending", 32'(swap_pending), 32'(0));
        tick();
        probe("same_cyc_write", 160, 20, 1'b1, 8'h99, 1'b1);
        probe("same_cyc_tile5", 100, 0, 1'b1, 8'h3C, 1'b1);

        // Out-of-range write.
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(768);
        wr_data = 8'hEE;
        tick();
        wr_en   = 1'b0;
        check("wr_err_pulse", 32'(wr_err), 32'(1));
        tick();
        check("wr_err_clear", 32'(wr_err), 32'(0));
        probe("oor_no_change", 100, 0, 1'b1, 8'h3C, 1'b1);

        // Double request while pending, then origin held four cycles.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("dbl_req_pending", 32'(swap_pending), 32'(1));
        cnt   = 0;
        pix_h = '0;
        pix_v = '0;
        for (int i = 0; i < 4; i++) begin
            #1 if (swap_done) cnt++;
            tick();
        end
        set_idle();
        tick();
        check("hold_done_count", 32'(cnt), 32'(1));
        check("hold_front", 32'(front_sel), 32'(0 ^ 1));
        check("hold_pending", 32'(swap_pending), 32'(0));

        // Request held high: one swap per frame.
        swap_req = 1'b1;
        tick();
        check("held_pending", 32'(swap_pending), 32'(1));
        frame(sd);
        check("held_done_a", 32'(sd), 32'(1));
        check("held_front_a", 32'(front_sel), 32'(0));
        frame(sd);
        check("held_done_b", 32'(sd), 32'(1));
        check("held_front_b", 32'(front_sel), 32'(1));
        swap_req = 1'b0;
        tick();
        check("held_pending_after", 32'(swap_pending), 32'(1));

        // Reset while pending discards the request.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pend_pending", 32'(swap_pending), 32'(0));
        check("rst_pend_front", 32'(front_sel), 32'(0));
        frame(sd);
        check("rst_pend_no_swap", 32'(sd), 32'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
